// File: rtl/dlsc_pcie_s6_outbound_read_buffer.sv
// Completion reorder buffer: stores completion words per PCIe tag and replays them
// onto the AXI R channel in tag-allocation order, returning each tag once drained.
module dlsc_pcie_s6_outbound_read_buffer #(
  parameter int TAG  = 5,
  parameter int SLOT = 5
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            alloc_valid,
  input  logic [TAG-1:0]  alloc_tag,
  input  logic [SLOT:0]   alloc_len,
  input  logic            alloc_burst_last,

  output logic            cpl_ready,
  input  logic            cpl_valid,
  input  logic            cpl_last,
  input  logic [31:0]     cpl_data,
  input  logic [1:0]      cpl_resp,
  input  logic [TAG-1:0]  cpl_tag,

  input  logic            axi_r_ready,
  output logic            axi_r_valid,
  output logic [31:0]     axi_r_data,
  output logic [1:0]      axi_r_resp,
  output logic            axi_r_last,

  output logic            dealloc_tag
);

  localparam int TAGS  = 2**TAG;
  localparam int DEPTH = TAGS * (2**SLOT);
  localparam int AW    = TAG + SLOT;

  logic [33:0]     mem [DEPTH];
  logic [33:0]     rd_q_reg;

  logic [SLOT:0]   len_reg   [TAGS];
  logic            blast_reg [TAGS];
  logic [SLOT:0]   wcnt_reg  [TAGS];

  logic [TAG-1:0]  rd_tag_reg;
  logic [SLOT:0]   rd_ptr_reg;
  logic            cpl_ready_reg;
  logic            valid_reg;
  logic            last_reg;
  logic            dealloc_reg;

  logic            cpl_we;
  logic [SLOT:0]   cpl_wcnt;
  logic [SLOT:0]   cpl_wcnt_next;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic [SLOT:0]   rd_wcnt;
  logic [SLOT:0]   rd_len;
  logic [SLOT:0]   rd_ptr_next;
  logic            rd_final;
  logic            issue;

  always_comb begin
    cpl_we        = cpl_valid && cpl_ready_reg;
    cpl_wcnt      = wcnt_reg[cpl_tag];
    cpl_wcnt_next = cpl_wcnt + (SLOT+1)'(1);
    wr_addr       = {cpl_tag, cpl_wcnt[SLOT-1:0]};
    rd_addr       = {rd_tag_reg, rd_ptr_reg[SLOT-1:0]};
    rd_wcnt       = wcnt_reg[rd_tag_reg];
    rd_len        = len_reg[rd_tag_reg];
    rd_ptr_next   = rd_ptr_reg + (SLOT+1)'(1);
    rd_final      = (rd_ptr_next == rd_len);
    // A word may be fetched only when it has landed and the output slot frees up this cycle
    issue         = (rd_ptr_reg != rd_wcnt) && (!valid_reg || axi_r_ready);
  end

  always_ff @(posedge clk) begin
    if (cpl_we) begin
      mem[wr_addr] <= {cpl_resp, cpl_data};
    end
  end

  // Read data register doubles as the R channel output holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q_reg <= '0;
    end else if (issue) begin
      rd_q_reg <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAGS; i++) begin
        wcnt_reg[i]  <= '0;
        len_reg[i]   <= '0;
        blast_reg[i] <= 1'b0;
      end
    end else begin
      if (cpl_we) begin
        wcnt_reg[cpl_tag] <= cpl_wcnt_next;
      end
      // Clearing a drained tag keeps a stale count from replaying old words after rd_tag wraps
      if (issue && rd_final) begin
        wcnt_reg[rd_tag_reg] <= '0;
      end
      if (alloc_valid) begin
        wcnt_reg[alloc_tag]  <= '0;
        len_reg[alloc_tag]   <= alloc_len;
        blast_reg[alloc_tag] <= alloc_burst_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_tag_reg    <= '0;
      rd_ptr_reg    <= '0;
      cpl_ready_reg <= 1'b0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
      dealloc_reg   <= 1'b0;
    end else begin
      cpl_ready_reg <= 1'b1;
      dealloc_reg   <= issue && rd_final;
      if (issue) begin
        valid_reg <= 1'b1;
        last_reg  <= blast_reg[rd_tag_reg] && rd_final;
        if (rd_final) begin
          rd_ptr_reg <= '0;
          rd_tag_reg <= rd_tag_reg + TAG'(1);
        end else begin
          rd_ptr_reg <= rd_ptr_next;
        end
      end else if (valid_reg && axi_r_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  // The completion stage must flag exactly the word that fills the tag's length
  always_ff @(posedge clk) begin
    if (cpl_we) begin
      assert (cpl_last == (cpl_wcnt_next == len_reg[cpl_tag]));
    end
  end

  assign cpl_ready   = cpl_ready_reg;
  assign axi_r_valid = valid_reg;
  assign axi_r_data  = rd_q_reg[31:0];
  assign axi_r_resp  = rd_q_reg[33:32];
  assign axi_r_last  = last_reg;
  assign dealloc_tag = dealloc_reg;

endmodule
